// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, the NOP encoding used for
// pipeline bubbles, and the common word type.
package cpu_pkg;

  localparam int DATA_W = 32;

  // sll $0,$0,0 -- architecturally a no-op, used for bubbles and reset
  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef logic [DATA_W-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/pipe_reg_en.sv
// Generic pipeline register field: async active-low reset, synchronous
// clear and load enable. Clear wins over enable so a bubble can always
// be injected regardless of whether the stage was about to advance.
module pipe_reg_en #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next value: clear beats load, otherwise hold
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = RST_VAL;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  // State register; reset acts immediately, independent of the clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : pipe_reg_en

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Captures the fetched instruction and its PC+4
// when startin is high, holds otherwise (stalling ID), and replaces the
// contents with a NOP bubble on flush. All outputs come straight from
// flops; there is no combinational path from any input.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int                DATA_W    = cpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              startin,
  input  logic              flush,
  input  logic [DATA_W-1:0] IF_instr,
  input  logic [DATA_W-1:0] IF_pc_plus_4,
  output logic [DATA_W-1:0] ID_instr,
  output logic [DATA_W-1:0] ID_pc_plus_4,
  output logic              ID_valid
);

  // Instruction field: bubbles and reset both present the NOP encoding
  pipe_reg_en #(
    .W       (DATA_W),
    .RST_VAL (NOP_INSTR)
  ) u_instr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .en_i  (startin),
    .d_i   (IF_instr),
    .q_o   (ID_instr)
  );

  // PC+4 field: cleared to zero on bubble/reset
  pipe_reg_en #(
    .W       (DATA_W),
    .RST_VAL ('0)
  ) u_pc_plus_4 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .en_i  (startin),
    .d_i   (IF_pc_plus_4),
    .q_o   (ID_pc_plus_4)
  );

  // Valid flag: set by every real capture, cleared by a bubble
  pipe_reg_en #(
    .W       (1),
    .RST_VAL (1'b0)
  ) u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .en_i  (startin),
    .d_i   (1'b1),
    .q_o   (ID_valid)
  );

endmodule : if_id_reg

// File: tb/tb_if_id_reg.sv
// Directed bench for the IF/ID pipeline register.
module tb_if_id_reg;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          startin;
  logic          flush;
  logic [DW-1:0] IF_instr;
  logic [DW-1:0] IF_pc_plus_4;
  logic [DW-1:0] ID_instr;
  logic [DW-1:0] ID_pc_plus_4;
  logic          ID_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  if_id_reg #(
    .DATA_W    (DW),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .startin      (startin),
    .flush        (flush),
    .IF_instr     (IF_instr),
    .IF_pc_plus_4 (IF_pc_plus_4),
    .ID_instr     (ID_instr),
    .ID_pc_plus_4 (ID_pc_plus_4),
    .ID_valid     (ID_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; startin = 1'b1;
    IF_instr = $urandom; IF_pc_plus_4 = $urandom;
    #2;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL reset_between_edges: got %h/%h/%b want 00000000/00000000/0",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL reset_across_edge: got %h/%h/%b want 00000000/00000000/0",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    // release mid-cycle with startin low: must stay at reset values
    @(negedge clk);
    startin = 1'b0; IF_instr = $urandom; IF_pc_plus_4 = $urandom;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL reset_release_no_load: got %h/%h/%b want 00000000/00000000/0",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
  endtask

  task automatic test_load_hold();
    @(negedge clk);
    IF_instr = 32'h1234_5678; IF_pc_plus_4 = 32'h4; startin = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h1234_5678, 32'h4, 1'b1})
      $display("FAIL load_first: got %h/%h/%b want 12345678/00000004/1",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    @(negedge clk);
    IF_instr = 32'h8765_4321; IF_pc_plus_4 = 32'h8; startin = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h1234_5678, 32'h4, 1'b1})
      $display("FAIL hold_first: got %h/%h/%b want 12345678/00000004/1",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    // startin pulse that does not span an edge
    @(negedge clk);
    #1 startin = 1'b1;
    #2 startin = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h1234_5678, 32'h4, 1'b1})
      $display("FAIL glitch_startin: got %h/%h/%b want 12345678/00000004/1",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
  endtask

  task automatic test_second_load();
    @(negedge clk);
    IF_instr = 32'h8765_4321; IF_pc_plus_4 = 32'h8; startin = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h8765_4321, 32'h8, 1'b1})
      $display("FAIL load_second: got %h/%h/%b want 87654321/00000008/1",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    @(negedge clk);
    IF_instr = 32'hDEAD_BEEF; IF_pc_plus_4 = 32'hC; startin = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h8765_4321, 32'h8, 1'b1})
      $display("FAIL hold_second: got %h/%h/%b want 87654321/00000008/1",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
  endtask

  task automatic test_flush_priority();
    @(negedge clk);
    IF_instr = 32'hDEAD_BEEF; IF_pc_plus_4 = 32'hC; startin = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL flush_over_startin: got %h/%h/%b want 00000000/00000000/0",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    // reload, then flush with startin low
    @(negedge clk);
    flush = 1'b0; IF_instr = 32'h0BAD_F00D; IF_pc_plus_4 = 32'h20;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h0BAD_F00D, 32'h20, 1'b1})
      $display("FAIL load_after_flush: got %h/%h/%b want 0badf00d/00000020/1",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    @(negedge clk);
    startin = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL flush_alone: got %h/%h/%b want 00000000/00000000/0",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    IF_instr = 32'hDEAD_BEEF; IF_pc_plus_4 = 32'hC; startin = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'hDEAD_BEEF, 32'hC, 1'b1})
      $display("FAIL load_before_rst: got %h/%h/%b want deadbeef/0000000c/1",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    // pending capture presented, then reset pulsed between edges
    @(negedge clk);
    IF_instr = 32'h1111_2222; IF_pc_plus_4 = 32'h10;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL async_clear_immediate: got %h/%h/%b want 00000000/00000000/0",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    startin = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL pending_lost: got %h/%h/%b want 00000000/00000000/0",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
    @(negedge clk);
    IF_instr = 32'hCAFE_F00D; IF_pc_plus_4 = 32'h14; startin = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'hCAFE_F00D, 32'h14, 1'b1})
      $display("FAIL load_after_rst: got %h/%h/%b want cafef00d/00000014/1",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] pcs [4];
    logic [DW-1:0] ins [4];
    pcs = '{32'h4, 32'h8, 32'hC, 32'h10};
    ins = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      IF_instr = ins[i]; IF_pc_plus_4 = pcs[i]; startin = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if ({ID_instr, ID_pc_plus_4, ID_valid} !== {ins[i], pcs[i], 1'b1})
        $display("FAIL stream[%0d]: got %h/%h/%b want %h/%h/1",
                 i, ID_instr, ID_pc_plus_4, ID_valid, ins[i], pcs[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    startin = 1'b0; IF_instr = 32'hFFFF_FFFF; IF_pc_plus_4 = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    total_cnt++;
    if ({ID_instr, ID_pc_plus_4, ID_valid} !== {32'hA000_0004, 32'h10, 1'b1})
      $display("FAIL stream_hold: got %h/%h/%b want a0000004/00000010/1",
               ID_instr, ID_pc_plus_4, ID_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_second_load();
    test_flush_priority();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_if_id_reg

// File: doc/if_id_reg.md
# if_id_reg

Pipeline register between the instruction-fetch (IF) and instruction-decode (ID) stages of the 5-stage CPU. On each rising clock edge where `startin` is asserted, it captures the fetched instruction and its PC+4 and presents them to ID. When not enabled, it holds its contents, which stalls the ID stage. A synchronous flush replaces the contents with a NOP bubble after a taken branch or jump.

## Interface
Parameters:
- `DATA_W`, 32: width of the instruction and PC words.
- `NOP_INSTR`, 32'h0000_0000: encoding loaded on flush and reset (`sll $0,$0,0`).

Ports:
- `clk`  in  1  rising-edge clock; the single clock of the block.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `startin`  in  1  load enable: 1 = capture IF values, 0 = hold.
- `flush`  in  1  synchronous bubble insert; has priority over `startin`.
- `IF_instr`  in  DATA_W  instruction fetched this cycle.
- `IF_pc_plus_4`  in  DATA_W  PC+4 of the fetched instruction.
- `ID_instr`  out  DATA_W  registered instruction to ID.
- `ID_pc_plus_4`  out  DATA_W  registered PC+4 to ID.
- `ID_valid`  out  1  1 = ID holds a real fetched instruction; 0 = bubble or reset value.

## Operation
- Reset (`rst_n`=0, takes effect immediately, independent of `clk`):
  - `ID_instr` = NOP_INSTR.
  - `ID_pc_plus_4` = 0.
  - `ID_valid` = 0.
- On each `posedge clk` with `rst_n`=1, evaluate in priority order:
  1. `flush`=1: `ID_instr`←NOP_INSTR, `ID_pc_plus_4`←0, `ID_valid`←0, regardless of `startin`.
  2. `startin`=1: `ID_instr`←`IF_instr`, `ID_pc_plus_4`←`IF_pc_plus_4`, `ID_valid`←1.
  3. Otherwise hold all outputs unchanged.
- Outputs are pure register outputs with no combinational path from any input.
- No arithmetic. Widths pass through unchanged.
- Changes on `IF_*` while `startin`=0 never reach the outputs.

## Timing
- Latency is 1 cycle: a value presented with `startin`=1 before edge N appears on the outputs just after edge N.
- Inputs are sampled only at the rising edge. `startin` pulses that do not span an edge have no effect.
- If `rst_n` is deasserted mid-cycle, the outputs stay at reset values until the first qualifying edge.
- If `rst_n` is asserted mid-operation, the outputs clear at once. Any pending capture is lost.
- `flush` and `startin` both high on the same edge: the flush wins, and the fetched instruction is discarded.
- Back-to-back `startin`=1 captures a new instruction on every edge, with no dead cycles.

## Structure
- The shared package `cpu_pkg` holds `DATA_W`, `NOP_INSTR`, and a `word_t` typedef (logic [DATA_W-1:0]).
- One natural sub-module, `pipe_reg_en`: a parameterised-width register with async active-low reset, synchronous clear (to a reset value), and enable.
  - It is instantiated once per field: instr, pc_plus_4, and valid.
  - The remaining pipeline registers reuse the same sub-module.

## Test plan
- Reset: drive `rst_n`=0 with random `IF_*` values -> `ID_instr`=0x00000000, `ID_pc_plus_4`=0, `ID_valid`=0, even between clock edges.
- Load and hold:
  - `IF_instr`=0x12345678, `IF_pc_plus_4`=0x4, `startin`=1 for one edge -> outputs 0x12345678/0x4, `ID_valid`=1.
  - Then `startin`=0 with `IF_instr`=0x87654321, `IF_pc_plus_4`=0x8 -> outputs stay 0x12345678/0x4.
- Second load: `startin`=1 with 0x87654321/0x8 -> outputs update on that edge only. Then 0xDEADBEEF/0xC with `startin`=0 -> outputs remain 0x87654321/0x8.
- Flush priority: `startin`=1 and `flush`=1 with 0xDEADBEEF/0xC -> outputs 0x00000000/0x0, `ID_valid`=0.
- Async reset mid-operation: after loading 0xDEADBEEF/0xC, pulse `rst_n` low between edges -> outputs clear immediately, not at the next edge. After release, the next `startin`=1 edge loads normally.
- Streaming: `startin`=1 for 4 consecutive edges with PC+4 values 0x4, 0x8, 0xC, 0x10 -> each value appears exactly one cycle after it is presented.
